// File: rtl/noc_rr_arbiter.sv
// Merges CPU_NB valid/ready request streams into one tagged stream through per-CPU FIFOs.
// Latency: a word accepted into an empty FIFO appears on out_vld one edge later.
// Backpressure: out_rdy low holds the output register; the FIFOs fill, then in_rdy drops per CPU.
module noc_rr_arbiter #(
    parameter int CPU_NB     = 4,
    parameter int FIFO_DEPTH = 4,
    localparam int SRC_W     = (CPU_NB > 1) ? $clog2(CPU_NB) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [CPU_NB-1:0]        in_vld,
    output logic [CPU_NB-1:0]        in_rdy,
    input  logic [CPU_NB-1:0][63:0]  in_data,
    output logic                     out_vld,
    input  logic                     out_rdy,
    output logic [63:0]              out_data,
    output logic [SRC_W-1:0]         out_src,
    output logic [31:0]              xfer_cnt
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] PTR_ONE = (PW+1)'(1);
    localparam logic [SRC_W-1:0] LAST_INIT = SRC_W'(CPU_NB - 1);

    logic [CPU_NB-1:0]       full;
    logic [CPU_NB-1:0]       empty;
    logic [CPU_NB-1:0]       push;
    logic [CPU_NB-1:0]       pop;
    logic [CPU_NB-1:0][63:0] head;

    logic [SRC_W-1:0] last_grant;
    logic [SRC_W-1:0] gnt_idx;
    logic             any_req;
    logic             load;
    logic             xfer;

    // in_rdy looks only at FIFO state, so a full FIFO stays closed even on a same-cycle pop.
    assign in_rdy = rst ? '0 : ~full;
    assign push   = in_vld & in_rdy;

    for (genvar g = 0; g < CPU_NB; g++) begin : g_fifo
        logic [PW:0] wr_ptr;
        logic [PW:0] rd_ptr;
        logic [63:0] mem [FIFO_DEPTH];

        always_ff @(posedge clk) begin
            if (rst) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push[g]) begin
                    wr_ptr <= wr_ptr + PTR_ONE;
                end
                if (pop[g]) begin
                    rd_ptr <= rd_ptr + PTR_ONE;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (push[g]) begin
                mem[wr_ptr[PW-1:0]] <= in_data[g];
            end
        end

        assign head[g]  = mem[rd_ptr[PW-1:0]];
        assign empty[g] = (wr_ptr == rd_ptr);
        assign full[g]  = (wr_ptr[PW] != rd_ptr[PW]) &&
                          (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    end

    // First non-empty FIFO after last_grant, wrapping around.
    always_comb begin
        gnt_idx = '0;
        any_req = 1'b0;
        for (int k = 1; k <= CPU_NB; k++) begin
            if (!any_req && !empty[(int'(last_grant) + k) % CPU_NB]) begin
                any_req = 1'b1;
                gnt_idx = SRC_W'((int'(last_grant) + k) % CPU_NB);
            end
        end
    end

    assign load = (!out_vld || out_rdy) && any_req;
    assign xfer = out_vld && out_rdy;

    always_comb begin
        pop = '0;
        if (load) begin
            pop[gnt_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld    <= 1'b0;
            out_data   <= '0;
            out_src    <= '0;
            last_grant <= LAST_INIT;
        end else if (load) begin
            out_vld    <= 1'b1;
            out_data   <= head[gnt_idx];
            out_src    <= gnt_idx;
            last_grant <= gnt_idx;
        end else if (xfer) begin
            out_vld    <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            xfer_cnt <= '0;
        end else if (xfer) begin
            xfer_cnt <= xfer_cnt + 32'd1;
        end
    end

endmodule

// File: doc/noc_rr_arbiter.md
Name: noc_rr_arbiter

Overview:
Upstream stage of the NOC sink. It merges CPU_NB per-CPU 64-bit valid/ready request streams into one valid/ready stream, tagged with the source CPU index. Each input has a small FIFO, and a round-robin arbiter drains the FIFOs into a registered output stage. It decouples CPU-side traffic from NOC-side backpressure, and no combinational path crosses from input to output.

Parameters:
CPU_NB, 4, number of CPU input streams (>=1)
FIFO_DEPTH, 4, entries per input FIFO (power of 2, >=2)
SRC_W, (CPU_NB>1 ? $clog2(CPU_NB) : 1), width of out_src (derived, not overridden)

Ports:
clk  input  1  single clock, all logic on posedge
rst  input  1  synchronous, active-high reset
in_vld[CPU_NB]  input  1 each  CPU request valid
in_rdy[CPU_NB]  output  1 each  FIFO can accept
in_data[CPU_NB]  input  64 each  CPU request payload
out_vld  output  1  merged stream valid
out_rdy  input  1  downstream (NOC) ready
out_data  output  64  merged payload
out_src  output  SRC_W  CPU index that produced out_data
xfer_cnt  output  32  count of completed output handshakes

Behaviour:
- Only posedge clk is used. rst is sampled synchronously, and rst has priority over every other event in that cycle.
- Reset values:
  - All FIFOs empty; out_vld=0, out_data=0, out_src=0, xfer_cnt=0.
  - Round-robin pointer last_grant=CPU_NB-1, so CPU 0 has first priority.
  - in_rdy[i]=0 while rst=1; otherwise in_rdy[i]=!full[i].
- Input push:
  - Push occurs when in_vld[i] && in_rdy[i] at the edge.
  - in_rdy[i] depends only on FIFO state, never on out_rdy or the current pop.
  - A full FIFO does not accept a word even if it is popped in the same cycle. in_rdy rises the cycle after the pop.
- Output load condition: load = (!out_vld || out_rdy) && any FIFO non-empty.
- Grant on load:
  - Pick the first non-empty FIFO scanning from (last_grant+1) mod CPU_NB upward with wrap.
  - Pop that FIFO; register its head into out_data and its index into out_src; set out_vld=1.
  - Set last_grant to the granted index.
- Output clear: if out_vld && out_rdy and there is no load, out_vld goes to 0. out_data and out_src keep their last value.
- Stability: while out_vld && !out_rdy, out_vld, out_data and out_src do not change, and no FIFO is popped.
- Throughput: one output word per cycle with sustained out_rdy=1 and non-empty FIFOs.
- Latency: a word accepted at edge E0 into an empty FIFO, with an idle output, gives out_vld=1 after edge E1.
- Simultaneous push and pop on one FIFO (not full) is allowed. Occupancy is unchanged and order is preserved.
- Per-source ordering is strictly FIFO. Interleaving between sources is round-robin, so with all inputs backlogged each source gets exactly 1 of every CPU_NB output slots.
- xfer_cnt increments by 1 on each edge where out_vld && out_rdy, and wraps 2^32-1 -> 0.
- Reset mid-operation:
  - All buffered and in-flight words are dropped; nothing is replayed after rst deasserts.
  - An in_vld asserted during rst is not accepted.
- CPU_NB=1: the arbiter degenerates to a FIFO plus output register, and out_src is always 0.
- FIFO pointers are $clog2(FIFO_DEPTH)+1 bits; the extra bit is the wrap flag that distinguishes full from empty.

Test Plan:
- Single source:
  - Stimulus: CPU 2 sends 0xA5A5_0000_0000_0001 with out_rdy=1.
  - Required: out_vld=1 one cycle after the accept edge, with out_src=2, the same data, and xfer_cnt=1.
- Round-robin fairness:
  - Stimulus: all 4 CPUs preloaded with 3 words each (data = cpu<<32 | seq), out_rdy=1.
  - Required: out_src sequence 0,1,2,3,0,1,2,3,0,1,2,3 on consecutive cycles, each source's seq increasing, xfer_cnt=12.
- Backpressure/full:
  - Stimulus: out_rdy=0, CPU 0 streams continuously.
  - Required: 1 word goes to the output register and 4 more are accepted, then in_rdy[0]=0.
  - Required: out_data is held stable; after out_rdy=1 the 5 words exit in order and in_rdy[0] rises the cycle after the first pop.
- Reset mid-operation:
  - Stimulus: assert rst for 1 cycle with 2 words queued on CPU 1 and out_vld=1.
  - Required: the next cycle has out_vld=0, xfer_cnt=0 and all in_rdy=1 (after rst low). The queued words never appear, and CPU 0 wins the first grant afterwards.
- Random NOC sink:
  - Stimulus: out_rdy randomized per cycle, and each CPU sends 10 words with random in_vld gaps.
  - Required: 40 handshakes in total, exact per-source order, no loss or duplication, no starvation of any source.
- Counter wrap:
  - Stimulus: force xfer_cnt to 0xFFFF_FFFF, then perform 1 handshake.
  - Required: xfer_cnt=0.
